// File: rtl/s_mem_checker.sv
// Read-checks all 256 locations of S memory against the identity pattern,
// tallying mismatches, the first failing address and sum/XOR signatures.
module s_mem_checker #(
  parameter int READ_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] q,
  output logic [7:0] address,
  output logic [1:0] memory_sel,
  output logic       wen,
  output logic       rd_mem_handler,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_err_addr,
  output logic [7:0] sum_chk,
  output logic [7:0] xor_chk,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [7:0]          tag_q [READ_LAT];
  logic [7:0]          tag_d [READ_LAT];
  logic [8:0]          err_q, err_d;
  logic [7:0]          first_q, first_d;
  logic                seen_q, seen_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          xor_q, xor_d;
  logic                pass_q, pass_d;
  logic                inner_busy;
  logic                sample;
  logic [7:0]          sample_tag;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The last stage is consumed on the edge leaving DRAIN, so only the
  // earlier stages need to be empty before moving on.
  always_comb begin
    inner_busy = 1'b0;
    for (int i = 0; i < READ_LAT - 1; i++) inner_busy = inner_busy | vld_q[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (addr_q == 8'hFF) state_d = DRAIN;
      DRAIN:   if (!inner_busy) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == ISSUE) || (state_q == DRAIN);
    rd_mem_handler = busy;
    memory_sel     = busy ? 2'b01 : 2'b00;
    done           = (state_q == DONE);
    dbg_state      = state_q;
  end

  always_comb begin
    vld_d[0] = (state_q == ISSUE);
    tag_d[0] = addr_q;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  assign sample     = vld_q[READ_LAT-1];
  assign sample_tag = tag_q[READ_LAT-1];

  always_comb begin
    addr_d  = addr_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    sum_d   = sum_q;
    xor_d   = xor_q;
    pass_d  = pass_q;
    if (state_q == IDLE && start) begin
      addr_d  = 8'd0;
      err_d   = 9'd0;
      first_d = 8'd0;
      seen_d  = 1'b0;
      sum_d   = 8'd0;
      xor_d   = 8'd0;
      pass_d  = 1'b0;
    end
    if (state_q == ISSUE && addr_q != 8'hFF) addr_d = addr_q + 8'd1;
    if (sample) begin
      sum_d = sum_q + q;
      xor_d = xor_q ^ q;
      if (q != sample_tag) begin
        if (err_q != 9'd256) err_d = err_q + 9'd1;
        if (!seen_q) begin
          first_d = sample_tag;
          seen_d  = 1'b1;
        end
      end
    end
    if (state_q == DRAIN && state_d == DONE) pass_d = (err_d == 9'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 8'd0;
      vld_q   <= '0;
      err_q   <= 9'd0;
      first_q <= 8'd0;
      seen_q  <= 1'b0;
      sum_q   <= 8'd0;
      xor_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      sum_q   <= sum_d;
      xor_q   <= xor_d;
      pass_q  <= pass_d;
    end
  end

  // Tags are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign address        = addr_q;
  assign wen            = 1'b0;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign sum_chk        = sum_q;
  assign xor_chk        = xor_q;

endmodule

// File: tb/tb_s_mem_checker.sv
// Bench for s_mem_checker: READ_LAT=2 and READ_LAT=1 instances, each fed by a
// delayed memory model; expected pass results are scoreboarded per instance.
module tb_s_mem_checker;

  localparam int W = 66;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [2];
  logic       start_s [2];
  logic [7:0] q_s     [2];
  logic [7:0] address_s [2];
  logic [1:0] msel_s  [2];
  logic       wen_s   [2];
  logic       rdm_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [8:0] err_s   [2];
  logic [7:0] first_s [2];
  logic [7:0] sum_s   [2];
  logic [7:0] xor_s   [2];
  logic [1:0] dbg_s   [2];

  s_mem_checker #(.READ_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .q(q_s[0]),
    .address(address_s[0]), .memory_sel(msel_s[0]), .wen(wen_s[0]),
    .rd_mem_handler(rdm_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .err_count(err_s[0]), .first_err_addr(first_s[0]),
    .sum_chk(sum_s[0]), .xor_chk(xor_s[0]), .dbg_state(dbg_s[0]));

  s_mem_checker #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .q(q_s[1]),
    .address(address_s[1]), .memory_sel(msel_s[1]), .wen(wen_s[1]),
    .rd_mem_handler(rdm_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .err_count(err_s[1]), .first_err_addr(first_s[1]),
    .sum_chk(sum_s[1]), .xor_chk(xor_s[1]), .dbg_state(dbg_s[1]));

  // Clock/reset bookkeeping and memory model
  int unsigned e = 0;
  always @(posedge clk) e <= e + 1;

  logic [7:0] mem [2][256];
  logic       issuing [2];
  logic [7:0] ah [2][4];
  logic       vh [2][4];
  logic [7:0] junk [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ah[u][0] <= address_s[u];
      vh[u][0] <= issuing[u];
      for (int i = 1; i < 4; i++) begin
        ah[u][i] <= ah[u][i-1];
        vh[u][i] <= vh[u][i-1];
      end
      junk[u] <= 8'($urandom);
    end
  end

  always_comb begin
    q_s[0] = vh[0][1] ? mem[0][ah[0][1]] : junk[0];
    q_s[1] = vh[1][0] ? mem[1][ah[1][0]] : junk[1];
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];
  logic [W-1:0] last_exp [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: compare every byte with its own address.
  function automatic logic [W-1:0] model(input int u, input int unsigned done_e);
    int  nerr  = 0;
    int  first = 0;
    bit  seen  = 0;
    int  sum   = 0;
    int  x     = 0;
    bit  ok;
    for (int i = 0; i < 256; i++) begin
      int v = int'(mem[u][i]);
      sum = sum + v;
      x   = x ^ v;
      if (v != i) begin
        nerr++;
        if (!seen) begin
          first = i;
          seen  = 1;
        end
      end
    end
    ok = (nerr == 0);
    return {done_e[31:0], ok, nerr[8:0], first[7:0], sum[7:0], x[7:0]};
  endfunction

  logic [W-1:0] mon_it;
  bit           mon_have;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done_s[u] === 1'b1) begin
        mon_have = 0;
        if (u == 0 && exp_q0.size() > 0) begin mon_it = exp_q0.pop_front(); mon_have = 1; end
        if (u == 1 && exp_q1.size() > 0) begin mon_it = exp_q1.pop_front(); mon_have = 1; end
        if (!mon_have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done u%0d: got done=1 expected none at t=%0t", u, $time);
        end else begin
          chk($sformatf("done_cycle u%0d", u), e, mon_it[65:34]);
          chk($sformatf("pass u%0d", u), 32'(pass_s[u]), 32'(mon_it[33]));
          chk($sformatf("err_count u%0d", u), 32'(err_s[u]), 32'(mon_it[32:24]));
          chk($sformatf("first_err u%0d", u), 32'(first_s[u]), 32'(mon_it[23:16]));
          chk($sformatf("sum_chk u%0d", u), 32'(sum_s[u]), 32'(mon_it[15:8]));
          chk($sformatf("xor_chk u%0d", u), 32'(xor_s[u]), 32'(mon_it[7:0]));
        end
      end
    end
  end

  // Driver tasks
  task automatic do_pass(input int u, input bit noise);
    int          lat;
    int unsigned eb;
    logic [W-1:0] it;
    bit          bsy;
    lat = (u == 0) ? 2 : 1;
    eb  = e + 1;
    it  = model(u, eb + 256 + lat);
    if (u == 0) exp_q0.push_back(it); else exp_q1.push_back(it);
    last_exp[u] = it;
    start_s[u]  = 1'b1;
    for (int k = 1; k <= 257 + lat; k++) begin
      @(negedge clk);
      start_s[u] = noise && (k == 50 || k == 257 + lat);
      issuing[u] = (k <= 256);
      bsy = (k < 257 + lat);
      chk($sformatf("address u%0d k%0d", u, k), 32'(address_s[u]), (k <= 256) ? k - 1 : 255);
      chk($sformatf("busy u%0d k%0d", u, k), 32'(busy_s[u]), 32'(bsy));
      chk($sformatf("rd_mem_handler u%0d k%0d", u, k), 32'(rdm_s[u]), 32'(bsy));
      chk($sformatf("memory_sel u%0d k%0d", u, k), 32'(msel_s[u]), bsy ? 1 : 0);
      chk($sformatf("done_level u%0d k%0d", u, k), 32'(done_s[u]), (k == 257 + lat) ? 1 : 0);
      chk($sformatf("wen u%0d", u), 32'(wen_s[u]), 0);
    end
    @(negedge clk);
    start_s[u] = 1'b0;
  endtask

  task automatic hold_check(input int u);
    repeat (5) @(negedge clk);
    chk($sformatf("hold_busy u%0d", u), 32'(busy_s[u]), 0);
    chk($sformatf("hold_pass u%0d", u), 32'(pass_s[u]), 32'(last_exp[u][33]));
    chk($sformatf("hold_err u%0d", u), 32'(err_s[u]), 32'(last_exp[u][32:24]));
    chk($sformatf("hold_first u%0d", u), 32'(first_s[u]), 32'(last_exp[u][23:16]));
    chk($sformatf("hold_sum u%0d", u), 32'(sum_s[u]), 32'(last_exp[u][15:8]));
    chk($sformatf("hold_xor u%0d", u), 32'(xor_s[u]), 32'(last_exp[u][7:0]));
  endtask

  task automatic check_cleared(input int u, input string tag);
    chk({tag, "_address"}, 32'(address_s[u]), 0);
    chk({tag, "_memory_sel"}, 32'(msel_s[u]), 0);
    chk({tag, "_rd_mem_handler"}, 32'(rdm_s[u]), 0);
    chk({tag, "_busy"}, 32'(busy_s[u]), 0);
    chk({tag, "_done"}, 32'(done_s[u]), 0);
    chk({tag, "_pass"}, 32'(pass_s[u]), 0);
    chk({tag, "_err"}, 32'(err_s[u]), 0);
    chk({tag, "_first"}, 32'(first_s[u]), 0);
    chk({tag, "_sum"}, 32'(sum_s[u]), 0);
    chk({tag, "_xor"}, 32'(xor_s[u]), 0);
    chk({tag, "_wen"}, 32'(wen_s[u]), 0);
  endtask

  task automatic fill(input int u, input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: mem[u][i] = 8'(i);
        1: mem[u][i] = 8'(i + 1);
        2: mem[u][i] = 8'd0;
        default: mem[u][i] = ($urandom_range(0, 1) == 1) ? 8'(i) : 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  int nd;

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset_s[u] = 1'b1;
      start_s[u] = 1'b1;
      issuing[u] = 1'b0;
      fill(u, 0);
    end
    repeat (3) @(negedge clk);
    check_cleared(0, "reset_u0");
    check_cleared(1, "reset_u1");
    chk("reset_state_u0", 32'(dbg_s[0]), 0);
    for (int u = 0; u < 2; u++) begin
      reset_s[u] = 1'b0;
      start_s[u] = 1'b0;
    end
    @(negedge clk);

    fill(0, 0);
    do_pass(0, 0);
    hold_check(0);
    fill(0, 0);
    mem[0][8'h37] = 8'h00;
    do_pass(0, 0);
    hold_check(0);
    fill(0, 2);
    do_pass(0, 0);
    hold_check(0);
    fill(0, 1);
    do_pass(0, 0);
    hold_check(0);
    for (int r = 0; r < 2; r++) begin
      fill(0, 3);
      do_pass(0, 0);
      hold_check(0);
    end

    // Abort a pass with reset held during cycle 100.
    fill(0, 3);
    start_s[0] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      issuing[0] = (k <= 256);
      if (k == 100) reset_s[0] = 1'b1;
    end
    @(negedge clk);
    reset_s[0] = 1'b0;
    issuing[0] = 1'b0;
    check_cleared(0, "abort");
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_s[0] === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);

    // Start pulses while busy and in DONE are ignored; the IDLE pulse chains.
    fill(0, 0);
    do_pass(0, 1);
    do_pass(0, 0);
    hold_check(0);

    fill(1, 0);
    do_pass(1, 0);
    hold_check(1);
    fill(1, 3);
    do_pass(1, 0);
    hold_check(1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty_u0", exp_q0.size(), 0);
    chk("scoreboard_empty_u1", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
